// File: rtl/parking_slot_manager.sv
// Parking-lot occupancy tracker: allocates the lowest free slot over a req/ack
// handshake, frees slots on exit strobes, and keeps registered count/flags.
module parking_slot_manager #(
  parameter int N_SLOTS = 8,
  parameter int CNT_W   = $clog2(N_SLOTS + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_en,
  input  logic [N_SLOTS-1:0] load_map,
  input  logic               enter_req,
  output logic               enter_ack,
  output logic [N_SLOTS-1:0] enter_location,
  input  logic               exit_valid,
  input  logic [N_SLOTS-1:0] exit_location,
  output logic [N_SLOTS-1:0] occupancy,
  output logic [CNT_W-1:0]   free_count,
  output logic               full,
  output logic               empty,
  output logic               exit_err
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT   = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  logic [1:0]         state_reg, state_next;
  logic [N_SLOTS-1:0] occ_reg, occ_next;
  logic [N_SLOTS-1:0] loc_reg, loc_next;
  logic               ack_reg, ack_next;
  logic               exit_err_reg, exit_err_next;
  logic [CNT_W-1:0]   free_count_reg, free_count_next;
  logic               full_reg, full_next;
  logic               empty_reg, empty_next;

  // Lowest-index free slot of the registered map, as a one-hot vector.
  logic [N_SLOTS:0]   seen_free;
  logic [N_SLOTS-1:0] lowest_free;
  assign seen_free[0] = 1'b0;
  for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_lowest
    assign seen_free[gi+1]  = seen_free[gi] | ~occ_reg[gi];
    assign lowest_free[gi]  = ~occ_reg[gi] & ~seen_free[gi];
  end

  logic               grant_start;
  logic               exit_legal;
  logic [N_SLOTS-1:0] bit_set, bit_clear;

  assign grant_start = (state_reg == IDLE) && enter_req && !full_reg && !load_en;
  // The slot being granted is still 0 in occ_reg, so exiting it is illegal.
  assign exit_legal  = exit_valid && !load_en && $onehot(exit_location) &&
                       |(exit_location & occ_reg);
  assign bit_set     = (state_reg == GRANT) ? loc_reg : '0;
  assign bit_clear   = exit_legal ? exit_location : '0;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_start) state_next = GRANT;
      GRANT:   state_next = RELEASE;
      RELEASE: if (!enter_req) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    occ_next      = load_en ? load_map : ((occ_reg | bit_set) & ~bit_clear);
    loc_next      = grant_start ? lowest_free : '0;
    ack_next      = grant_start;
    exit_err_next = exit_valid && !load_en && !exit_legal;
    full_next     = &occ_next;
    empty_next    = ~|occ_next;
    free_count_next = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      free_count_next = free_count_next + {{(CNT_W-1){1'b0}}, ~occ_next[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      occ_reg        <= '0;
      loc_reg        <= '0;
      ack_reg        <= 1'b0;
      exit_err_reg   <= 1'b0;
      free_count_reg <= CNT_W'(N_SLOTS);
      full_reg       <= 1'b0;
      empty_reg      <= 1'b1;
    end else begin
      state_reg      <= state_next;
      occ_reg        <= occ_next;
      loc_reg        <= loc_next;
      ack_reg        <= ack_next;
      exit_err_reg   <= exit_err_next;
      free_count_reg <= free_count_next;
      full_reg       <= full_next;
      empty_reg      <= empty_next;
    end
  end

  assign enter_ack      = ack_reg;
  assign enter_location = loc_reg;
  assign occupancy      = occ_reg;
  assign free_count     = free_count_reg;
  assign full           = full_reg;
  assign empty          = empty_reg;
  assign exit_err       = exit_err_reg;

endmodule

// File: doc/parking_slot_manager.md
Name: parking_slot_manager

Overview:
Sequential, parametrised successor to the combinational capacity-update logic. Holds the occupancy bitmap of an N-slot parking lot in registers. Serves entry requests by allocating the lowest-index free slot over a req/ack handshake. Frees slots on exit events and keeps free count, full/empty flags and error pulses for the gate controller and display logic.

Parameters:
N_SLOTS, 8, number of parking slots; bitmap width; legal range 2..32.
CNT_W, $clog2(N_SLOTS+1), width of free_count; derived, not overridden.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
load_en  input  1  one-cycle strobe; replace bitmap with load_map.
load_map  input  N_SLOTS  new occupancy bitmap (1 = occupied).
enter_req  input  1  entry request level, held until enter_ack seen.
enter_ack  output  1  one-cycle grant pulse.
enter_location  output  N_SLOTS  one-hot allocated slot; valid while enter_ack=1, else 0.
exit_valid  input  1  one-cycle exit strobe.
exit_location  input  N_SLOTS  one-hot slot being vacated.
occupancy  output  N_SLOTS  registered bitmap.
free_count  output  CNT_W  number of zero bits in occupancy.
full  output  1  occupancy all ones.
empty  output  1  occupancy all zeros.
exit_err  output  1  one-cycle pulse on illegal exit.

Behaviour:
- Reset, asynchronous: occupancy=0, free_count=N_SLOTS, full=0, empty=1, enter_ack=0, enter_location=0, exit_err=0, FSM=IDLE. Reset mid-handshake drops any pending grant; no slot stays allocated.
- Entry FSM states: IDLE, GRANT, RELEASE.
  - IDLE -> GRANT when enter_req=1 and full=0 and load_en=0. Slot = lowest-index 0 bit of the registered occupancy.
  - GRANT lasts one cycle: enter_ack=1, enter_location=one-hot slot, and the slot bit is set at the end of the cycle. Latency is req sampled at edge k, ack high in cycle k+1.
  - GRANT -> RELEASE always.
  - RELEASE -> IDLE when enter_req=0. This gives one grant per request level, so a held req never causes a double allocation.
  - While full=1, IDLE holds. enter_req is left pending and is granted once a slot frees.
- Exit, evaluated every cycle independently of the FSM:
  - Legal when exit_valid=1, exit_location is exactly one-hot, and that bit is set in occupancy. The bit is cleared at the next edge.
  - Otherwise, when exit_valid=1: no bitmap change, and exit_err=1 for the next cycle. This covers zero, multi-hot, or an already-free slot.
- Simultaneous exit and GRANT in the same cycle:
  - Both apply: bit_set for the grant, bit_clear for the exit, free_count net unchanged.
  - Exiting the slot being granted in that same cycle is illegal, because the slot is still 0 in the registered map. This raises exit_err and the grant wins.
- A slot freed in cycle k is allocatable only from cycle k+1, since allocation uses registered state.
- load_en has top priority:
  - occupancy <= load_map.
  - An exit in the same cycle is ignored, with no exit_err.
  - IDLE does not grant in that cycle.
  - A GRANT in progress still pulses ack, but its bit-set is discarded in favour of load_map. The controller must not load during a handshake.
- free_count, full and empty are registered and consistent with occupancy on the same cycle (computed from next-state). free_count never wraps: range 0..N_SLOTS.
- All outputs registered; no combinational input-to-output paths.

Test Plan:
1. Reset then enter_req=1 held 5 cycles (N=8) -> single ack in cycle 1 after req, enter_location=8'b00000001, occupancy=8'b00000001, free_count=7, no second ack until req drops.
2. load_map=8'b11000000, then three req pulses -> grants 8'b00000001, 8'b00000010, 8'b00000100; final occupancy=8'b11000111, free_count=3.
3. load_map=8'hFF, enter_req=1 -> full=1, no ack. Exit 8'b00010000 -> next cycle occupancy=8'hEF, full=0. Ack follows with enter_location=8'b00010000, then occupancy=8'hFF again.
4. occupancy=8'b00100010, exit_location=8'b00000001 -> exit_err pulse, map unchanged. Then exit_location=8'b00100010 (multi-hot) -> exit_err, map unchanged.
5. occupancy=8'b00000011, GRANT of slot 2 concurrent with exit of 8'b00000001 -> occupancy=8'b00000110, free_count stays 6.
6. Assert rst_n=0 asynchronously during GRANT -> outputs return to reset values immediately (before next clk edge); after release, new req granted slot 0.
